// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// Build option SERIAL_SUB_SAT_EN (used by serial_subtractor) selects a saturating result.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter width: enough to index bits 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/subtractor_1bit.sv
// Combinational 1-bit full subtractor cell: diff = a - b - borrow_in.
module subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial NUM_BITS-wide subtractor (a - b - borrow_in), LSB first, start/busy/done handshake.
// Define SERIAL_SUB_SAT_EN to clamp the result to zero when the final borrow is set.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                underflow
);

  localparam int CNT_W = cnt_width(NUM_BITS);

  state_t              state_reg, state_next;
  logic [NUM_BITS-1:0] a_sr_reg, b_sr_reg, res_sr_reg, diff_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                brw_reg, underflow_reg, busy_reg, done_reg;

  logic                cell_d, cell_bo, last_bit;
  logic [NUM_BITS-1:0] result_full, result_final;

  subtractor_1bit u_cell (
    .a         (a_sr_reg[0]),
    .b         (b_sr_reg[0]),
    .borrow_in (brw_reg),
    .diff      (cell_d),
    .borrow_out(cell_bo)
  );

  assign last_bit    = (cnt_reg == CNT_W'(NUM_BITS - 1));
  assign result_full = {cell_d, res_sr_reg[NUM_BITS-1:1]};

`ifdef SERIAL_SUB_SAT_EN
  assign result_final = cell_bo ? '0 : result_full;
`else
  assign result_final = result_full;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_reg      <= '0;
      b_sr_reg      <= '0;
      res_sr_reg    <= '0;
      diff_reg      <= '0;
      cnt_reg       <= '0;
      brw_reg       <= 1'b0;
      underflow_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      busy_reg <= (state_next != IDLE);
      done_reg <= (state_next == DONE);
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sr_reg   <= a;
            b_sr_reg   <= b;
            brw_reg    <= borrow_in;
            res_sr_reg <= '0;
            cnt_reg    <= '0;
          end
        end
        SHIFT: begin
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          res_sr_reg <= result_full;
          brw_reg    <= cell_bo;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          // diff only changes here, so partial sums never reach the output
          if (last_bit) begin
            diff_reg      <= result_final;
            underflow_reg <= cell_bo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign diff      = diff_reg;
  assign underflow = underflow_reg;

endmodule
